// File: rtl/eeprom_pkg.sv
// Shared encodings for the 24LC64 access scheduler: engine command codes, FSM states and
// the step indices that carry special meaning in the command table.
package eeprom_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_ACK  = 3'd3;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  localparam logic [3:0] CTRL_PREFIX = 4'b1010;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  typedef enum logic {
    OpWrite = 1'b0,
    OpRead  = 1'b1
  } op_e;

  // Write: 0..5 byte write, 6..8 one ACK-poll sequence. Read: 0..7 random read.
  localparam logic [3:0] STEP_POLL_START = 4'd6;
  localparam logic [3:0] STEP_POLL_CTRL  = 4'd7;
  localparam logic [3:0] STEP_POLL_STOP  = 4'd8;
  localparam logic [3:0] STEP_RD_DATA    = 4'd6;
  localparam logic [3:0] STEP_RD_STOP    = 4'd7;

  function automatic logic [7:0] ctrl_byte(input logic [2:0] dev, input logic rw);
    return {CTRL_PREFIX, dev, rw};
  endfunction

endpackage

// File: rtl/eeprom_rr_arb.sv
// Two-way round-robin arbiter: a lone request is granted outright, a tie goes to the
// requester that was not served last.
module eeprom_rr_arb
  import eeprom_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  op_e  last_served,
  output logic grant,
  output op_e  grant_op
);

  always_comb begin
    grant = wr_req | rd_req;
    if (wr_req && rd_req) begin
      grant_op = (last_served == OpRead) ? OpWrite : OpRead;
    end else if (rd_req) begin
      grant_op = OpRead;
    end else begin
      grant_op = OpWrite;
    end
  end

endmodule

// File: rtl/eeprom_access_sched.sv
// Schedules 24LC64 byte writes (with ACK polling) and random reads onto a byte-level I2C
// engine, one command outstanding at a time.
module eeprom_access_sched
  import eeprom_pkg::*;
#(
  parameter logic [2:0]  DEV_SEL  = 3'b000,
  parameter int unsigned MAX_POLL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [12:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_ack,
  output logic        err,
  output logic        busy,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [7:0]  cmd_wdata,
  input  logic        cmd_ready,
  input  logic        eng_done,
  input  logic        eng_nack,
  input  logic [7:0]  eng_rdata
);

  localparam logic [7:0] PollMax = 8'(MAX_POLL);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  op_e         last_q, last_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        poll_nack_q, poll_nack_d;
  logic        abort_q, abort_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic        grant;
  op_e         grant_op;
  logic [2:0]  step_cmd;
  logic [7:0]  step_wdata;
  logic        is_poll_ctrl;

  eeprom_rr_arb u_arb (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .last_served (last_q),
    .grant       (grant),
    .grant_op    (grant_op)
  );

  // Command table indexed by operation and step; an abort overrides with a bus release.
  always_comb begin
    step_cmd   = CMD_NOP;
    step_wdata = 8'h00;
    if (abort_q) begin
      step_cmd = CMD_STOP;
    end else if (op_q == OpWrite) begin
      case (step_q)
        4'd0: step_cmd = CMD_START;
        4'd1: begin step_cmd = CMD_WRITE; step_wdata = ctrl_byte(DEV_SEL, 1'b0); end
        4'd2: begin step_cmd = CMD_WRITE; step_wdata = {3'b000, addr_q[12:8]}; end
        4'd3: begin step_cmd = CMD_WRITE; step_wdata = addr_q[7:0]; end
        4'd4: begin step_cmd = CMD_WRITE; step_wdata = data_q; end
        4'd5: step_cmd = CMD_STOP;
        4'd6: step_cmd = CMD_START;
        4'd7: begin step_cmd = CMD_WRITE; step_wdata = ctrl_byte(DEV_SEL, 1'b0); end
        4'd8: step_cmd = CMD_STOP;
        default: step_cmd = CMD_NOP;
      endcase
    end else begin
      case (step_q)
        4'd0: step_cmd = CMD_START;
        4'd1: begin step_cmd = CMD_WRITE; step_wdata = ctrl_byte(DEV_SEL, 1'b0); end
        4'd2: begin step_cmd = CMD_WRITE; step_wdata = {3'b000, addr_q[12:8]}; end
        4'd3: begin step_cmd = CMD_WRITE; step_wdata = addr_q[7:0]; end
        4'd4: step_cmd = CMD_START;
        4'd5: begin step_cmd = CMD_WRITE; step_wdata = ctrl_byte(DEV_SEL, 1'b1); end
        4'd6: step_cmd = CMD_READ_NACK;
        4'd7: step_cmd = CMD_STOP;
        default: step_cmd = CMD_NOP;
      endcase
    end
  end

  assign is_poll_ctrl = (op_q == OpWrite) && (step_q == STEP_POLL_CTRL) && !abort_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    last_d      = last_q;
    addr_d      = addr_q;
    data_d      = data_q;
    step_d      = step_q;
    poll_cnt_d  = poll_cnt_q;
    poll_nack_d = poll_nack_q;
    abort_d     = abort_q;
    rbuf_d      = rbuf_q;
    rd_data_d   = rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          op_d    = grant_op;
          state_d = StLoad;
        end
      end
      StLoad: begin
        addr_d      = (op_q == OpWrite) ? wr_addr : rd_addr;
        data_d      = wr_data;
        step_d      = 4'd0;
        poll_cnt_d  = 8'd0;
        poll_nack_d = 1'b0;
        abort_d     = 1'b0;
        state_d     = StIssue;
      end
      StIssue: begin
        if (cmd_ready) state_d = StWait;
      end
      StWait: begin
        if (eng_done) begin
          state_d = StIssue;
          if (abort_q) begin
            state_d = StErr;
          end else if (step_cmd == CMD_WRITE && eng_nack && !is_poll_ctrl) begin
            abort_d = 1'b1;
          end else if (op_q == OpWrite && step_q == STEP_POLL_STOP) begin
            if (!poll_nack_q) begin
              state_d = StDone;
            end else if (poll_cnt_q + 8'd1 == PollMax) begin
              state_d = StErr;
            end else begin
              poll_cnt_d  = poll_cnt_q + 8'd1;
              poll_nack_d = 1'b0;
              step_d      = STEP_POLL_START;
            end
          end else if (op_q == OpRead && step_q == STEP_RD_STOP) begin
            rd_data_d = rbuf_q;
            state_d   = StDone;
          end else begin
            step_d = step_q + 4'd1;
            if (is_poll_ctrl) poll_nack_d = eng_nack;
            if (op_q == OpRead && step_q == STEP_RD_DATA) rbuf_d = eng_rdata;
          end
        end
      end
      StDone, StErr: begin
        last_d  = op_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpWrite;
      last_q      <= OpRead;
      addr_q      <= '0;
      data_q      <= '0;
      step_q      <= '0;
      poll_cnt_q  <= '0;
      poll_nack_q <= 1'b0;
      abort_q     <= 1'b0;
      rbuf_q      <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      step_q      <= step_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_nack_q <= poll_nack_d;
      abort_q     <= abort_d;
      rbuf_q      <= rbuf_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_comb begin
    cmd_valid = (state_q == StIssue);
    cmd       = cmd_valid ? step_cmd : CMD_NOP;
    cmd_wdata = (cmd_valid && step_cmd == CMD_WRITE) ? step_wdata : 8'h00;
    wr_ack    = (state_q == StDone) && (op_q == OpWrite);
    rd_ack    = (state_q == StDone) && (op_q == OpRead);
    err       = (state_q == StErr);
    busy      = (state_q != StIdle);
    rd_data   = rd_data_q;
  end

endmodule

// File: tb/tb_eeprom_access_sched.sv
// Directed bench for eeprom_access_sched with a randomised-ready I2C engine model.
module tb_eeprom_access_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [12:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, rd_ack, err, busy;
  logic [7:0]  rd_data;
  logic        cmd_valid, cmd_ready, eng_done, eng_nack;
  logic [2:0]  cmd;
  logic [7:0]  cmd_wdata, eng_rdata;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  eeprom_access_sched #(
    .DEV_SEL  (3'b000),
    .MAX_POLL (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .err       (err),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack),
    .eng_rdata (eng_rdata)
  );

  // Engine model: accepted commands are logged as {cmd, wdata}; nack_mask is indexed by log position.
  logic [10:0] tr_q[$];
  logic [10:0] exp_q[$];
  logic [63:0] nack_mask = '0;
  logic [7:0]  rd_byte = 8'h00;
  int          dcnt = 0;
  int          rwait = -1;
  logic        p_nack = 1'b0;
  logic [7:0]  p_rdata = 8'h00;

  initial begin
    cmd_ready = 1'b0;
    eng_done  = 1'b0;
    eng_nack  = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      eng_done  = 1'b0;
      eng_nack  = 1'b0;
      cmd_ready = 1'b0;
      if (!rst_n) begin
        dcnt  = 0;
        rwait = -1;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            eng_done  = 1'b1;
            eng_nack  = p_nack;
            eng_rdata = p_rdata;
          end
        end
        if (cmd_valid && dcnt == 0 && !eng_done) begin
          if (rwait < 0) rwait = int'($urandom_range(0, 3));
          if (rwait == 0) begin
            cmd_ready = 1'b1;
            rwait     = -1;
            p_nack    = nack_mask[tr_q.size()];
            p_rdata   = (cmd == 3'd4) ? rd_byte : 8'hEE;
            tr_q.push_back({cmd, cmd_wdata});
            dcnt      = 5;
          end else begin
            rwait--;
          end
        end
      end
    end
  end

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    if (wr_ack)  wr_cnt  <= wr_cnt + 1;
    if (rd_ack)  rd_cnt  <= rd_cnt + 1;
    if (err)     err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void ex(input logic [2:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
  endfunction

  task automatic check_trace(input string tag);
    check({tag, "_len"}, 32'(tr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tr_q.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), 32'(tr_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // kind: 1 = wr_ack, 2 = rd_ack, 3 = err, 0 = nothing within the cycle budget
  task automatic wait_evt(output int kind);
    kind = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (wr_ack) begin kind = 1; break; end
      if (rd_ack) begin kind = 2; break; end
      if (err)    begin kind = 3; break; end
    end
  endtask

  task automatic new_test(input logic [63:0] mask);
    @(posedge clk);
    #1;
    tr_q.delete();
    nack_mask = mask;
  endtask

  task automatic ex_write_body(input logic [12:0] a, input logic [7:0] d);
    ex(3'd1, 8'h00); ex(3'd2, 8'hA0); ex(3'd2, {3'b000, a[12:8]}); ex(3'd2, a[7:0]);
    ex(3'd2, d); ex(3'd5, 8'h00);
  endtask

  task automatic ex_poll();
    ex(3'd1, 8'h00); ex(3'd2, 8'hA0); ex(3'd5, 8'h00);
  endtask

  int k, w0, r0, e0;

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_wdata", cmd_wdata, 0);
    check("rst_acks", {wr_ack, rd_ack, err}, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // 1: write 0x0123 <- 0xA5, poll ACKed first time
    new_test(64'd0);
    wr_addr = 13'h0123; wr_data = 8'hA5; wr_req = 1'b1;
    wait_evt(k);
    wr_req = 1'b0;
    check("t1_kind", k, 1);
    check("t1_busy_at_ack", busy, 1);
    ex_write_body(13'h0123, 8'hA5); ex_poll();
    check_trace("t1_trace");
    @(posedge clk);
    #1;
    check("t1_busy_after", busy, 0);
    check("t1_wr_cnt", wr_cnt, 1);

    // 2: first three polls NACKed
    e0 = err_cnt;
    new_test((64'd1 << 7) | (64'd1 << 10) | (64'd1 << 13));
    wr_req = 1'b1;
    wait_evt(k);
    wr_req = 1'b0;
    check("t2_kind", k, 1);
    ex_write_body(13'h0123, 8'hA5);
    repeat (4) ex_poll();
    check_trace("t2_trace");
    check("t2_no_err", err_cnt, e0);

    // 3: read 0x1FFF returning 0x3C
    new_test(64'd0);
    rd_byte = 8'h3C; rd_addr = 13'h1FFF; rd_req = 1'b1;
    wait_evt(k);
    rd_req = 1'b0;
    check("t3_kind", k, 2);
    check("t3_rd_data", rd_data, 8'h3C);
    ex(3'd1, 8'h00); ex(3'd2, 8'hA0); ex(3'd2, 8'h1F); ex(3'd2, 8'hFF);
    ex(3'd1, 8'h00); ex(3'd2, 8'hA1); ex(3'd4, 8'h00); ex(3'd5, 8'h00);
    check_trace("t3_trace");
    @(posedge clk);
    #1;
    check("t3_rd_data_held", rd_data, 8'h3C);

    // 4: simultaneous requests, write re-raised after its ack -> W, R, W
    new_test(64'd0);
    w0 = wr_cnt; r0 = rd_cnt;
    rd_byte = 8'h5A;
    wr_addr = 13'h0005; wr_data = 8'h11; rd_addr = 13'h0006;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_evt(k);
    check("t4_first", k, 1);
    wr_addr = 13'h0007; wr_data = 8'h22;
    wait_evt(k);
    rd_req = 1'b0;
    check("t4_second", k, 2);
    check("t4_rd_data", rd_data, 8'h5A);
    wait_evt(k);
    wr_req = 1'b0;
    check("t4_third", k, 1);
    @(posedge clk);
    #1;
    check("t4_wr_cnt", wr_cnt - w0, 2);
    check("t4_rd_cnt", rd_cnt - r0, 1);

    // 5a: NACK on address-high byte -> STOP, err, no wr_ack
    new_test(64'd1 << 2);
    w0 = wr_cnt; e0 = err_cnt;
    wr_addr = 13'h0123; wr_data = 8'hA5; wr_req = 1'b1;
    wait_evt(k);
    wr_req = 1'b0;
    check("t5a_kind", k, 3);
    ex(3'd1, 8'h00); ex(3'd2, 8'hA0); ex(3'd2, 8'h01); ex(3'd5, 8'h00);
    check_trace("t5a_trace");
    @(posedge clk);
    #1;
    check("t5a_no_wr_ack", wr_cnt, w0);
    check("t5a_err_cnt", err_cnt - e0, 1);

    // 5b: all MAX_POLL=4 polls NACKed -> err
    new_test((64'd1 << 7) | (64'd1 << 10) | (64'd1 << 13) | (64'd1 << 16));
    w0 = wr_cnt;
    wr_req = 1'b1;
    wait_evt(k);
    wr_req = 1'b0;
    check("t5b_kind", k, 3);
    ex_write_body(13'h0123, 8'hA5);
    repeat (4) ex_poll();
    check_trace("t5b_trace");
    check("t5b_no_wr_ack", wr_cnt, w0);

    // 6: reset while the read waits on the engine, then a fresh write
    new_test(64'd0);
    r0 = rd_cnt;
    rd_addr = 13'h0010; rd_req = 1'b1;
    k = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (tr_q.size() >= 3) begin k = 1; break; end
    end
    check("t6_reached_wait", k, 1);
    #1;
    rst_n = 1'b0; rd_req = 1'b0;
    @(posedge clk);
    #1;
    check("t6_cmd_valid", cmd_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_rd_data_cleared", rd_data, 0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("t6_no_rd_ack", rd_cnt, r0);
    new_test(64'd0);
    wr_addr = 13'h0042; wr_data = 8'h99; wr_req = 1'b1;
    wait_evt(k);
    wr_req = 1'b0;
    check("t6_new_write", k, 1);
    ex_write_body(13'h0042, 8'h99); ex_poll();
    check_trace("t6_trace");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
